instr_fetch_unit: RTL

- Fetch stage upstream of instruction decode.
- Generates sequential instruction addresses to the synchronous-read instruction memory and buffers returned words with their PCs in a small prefetch queue.
- Presents {pc, instr} to decode via valid/ready.
- Accepts a redirect (branch/jump target) that flushes all queued and in-flight fetches.

---
 rtl/instr_fetch_unit_pkg.sv | 14 +
 rtl/instr_fetch_unit_fifo.sv | 59 +++++
 rtl/instr_fetch_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg
//   Shared constants for the fetch stage: default address/instruction widths,
//   the default reset PC and the NOP encoding that decode uses to insert bubbles.
package instr_fetch_unit_pkg;

    localparam int          IFU_INSTR_MEM_WIDTH = 32;
    localparam int          IFU_INSTR_WIDTH     = 32;
    localparam logic [31:0] IFU_RESET_PC        = 32'h0000_0000;
    localparam logic [31:0] IFU_NOP_INSTR       = 32'h0000_0013;  // addi x0, x0, 0

    // Instructions are word aligned; a fetch PC always has its two LSBs clear.
    localparam int          IFU_PC_STEP         = 4;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo
//   Synchronous FIFO holding {pc, instr} prefetch entries.
//   Ports:
//     clk, rst   clock and synchronous active-high reset (clears storage too)
//     flush      drop all entries; wins over push/pop
//     push/push_data   write an entry at the tail
//     pop        retire the head entry
//     count      number of valid entries (0..DEPTH)
//     head       content of the head entry, combinational
//   The caller guarantees no push when full and no pop when empty.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Pointers are PW bits wide, so DEPTH being a power of two makes them wrap
    // for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage: issues sequential word addresses to a 1-cycle synchronous
//   instruction memory, queues returned words with their PCs and hands them to
//   decode over valid/ready. A redirect flushes queued and in-flight fetches.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     imem_re, imem_addr          memory request (addr = fetch_pc at all times)
//     imem_instr                  memory data, valid the cycle after imem_re
//     redirect_valid, redirect_pc branch/jump target, low two bits ignored
//     out_valid, out_ready        handshake to decode
//     out_pc, out_instr           head entry of the prefetch queue
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = IFU_INSTR_MEM_WIDTH,
    parameter int                    INSTR_WIDTH = IFU_INSTR_WIDTH,
    parameter int                    DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(IFU_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_re,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = ADDR_WIDTH + INSTR_WIDTH;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  inflight;
    logic [CW-1:0]         count;
    logic [CW:0]           occupancy;
    logic                  credit_ok;
    logic                  push;
    logic                  pop;
    logic [EW-1:0]         head;
    logic [ADDR_WIDTH-1:0] redirect_aligned;
    logic                  unused_redirect_lsbs;

    // Queued entries plus the outstanding request must fit. A pop in the same
    // cycle is deliberately not credited, so a full queue resumes fetching
    // one cycle after the pop.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign credit_ok = occupancy < (CW+1)'(DEPTH);

    assign imem_re   = !rst && !redirect_valid && credit_ok;
    assign imem_addr = fetch_pc;

    assign redirect_aligned     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_re;
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
            end else if (imem_re) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + ADDR_WIDTH'(IFU_PC_STEP);
            end
        end
    end

    // A response landing in a redirect cycle belongs to the old stream.
    assign push = !rst && inflight && !redirect_valid;

    assign out_valid = !rst && (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({req_pc, imem_instr}),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    assign out_pc    = head[EW-1:INSTR_WIDTH];
    assign out_instr = head[INSTR_WIDTH-1:0];

endmodule
